// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared constants, player state and symbol decode for the memory game
package memory_game_pkg;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 25;
    localparam int PAT_W   = SYM_W * MAX_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } player_state_t;

    function automatic logic [7:0] sym_to_onehot(input logic [2:0] sym);
        return 8'b0000_0001 << sym;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - load/count/expire timer advanced only on tick strobes
module tick_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    input  logic             i_tick_en,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_limit;

    // A load restarts the count at 0; expiry is the tick that lands on the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_limit <= '0;
        end else if (i_load) begin
            r_cnt   <= '0;
            r_limit <= i_limit;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_limit <= '0;
        end else if (i_tick_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_tick_en && (r_cnt == r_limit);

endmodule

// File: rtl/pattern_player.sv
// rtl/pattern_player.sv - timed one-hot LED playback of a latched symbol pattern
module pattern_player #(
    parameter  int SYM_W     = memory_game_pkg::SYM_W,
    parameter  int MAX_LEN   = memory_game_pkg::MAX_LEN,
    parameter  int ON_TICKS  = 2,
    parameter  int OFF_TICKS = 1,
    parameter  int CNT_W     = 16,
    localparam int PAT_W     = SYM_W * MAX_LEN,
    localparam int LED_W     = 1 << SYM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             reverse,
    input  logic [CNT_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             tick_en,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    import memory_game_pkg::*;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int OFS_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int T_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    player_state_t r_state;
    player_state_t w_next_state;

    logic [PAT_W-1:0] r_snap;
    logic             r_rev;
    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_idx;

    logic [LEN_W-1:0] w_eff_len;
    logic             w_accept;
    logic             w_last;
    logic             w_expire;
    logic             w_tmr_load;
    logic             w_tmr_clear;
    logic [T_W-1:0]   w_tmr_limit;
    logic [OFS_W-1:0] w_ofs;
    logic [SYM_W-1:0] w_sym;

    assign w_eff_len = (len > CNT_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(len);
    assign w_accept  = (r_state == IDLE) && start && !abort;

    // Forward walks k down to 0 (oldest first); reverse walks k up to eff_len-1.
    assign w_last = r_rev ? (LEN_W'(r_idx) == (r_len - LEN_W'(1))) : (r_idx == '0);

    assign w_ofs = OFS_W'(r_idx) * OFS_W'(SYM_W);
    assign w_sym = r_snap[w_ofs +: SYM_W];

    assign w_tmr_clear = (r_state == IDLE) || (r_state == DONE);

    tick_timer #(
        .CNT_W (T_W)
    ) u_tick_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_load    (w_tmr_load),
        .i_limit   (w_tmr_limit),
        .i_tick_en (tick_en),
        .o_expire  (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_limit  = T_W'(ON_TICKS - 1);
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_eff_len == '0) begin
                            w_next_state = DONE;
                        end else begin
                            w_next_state = SHOW;
                            w_tmr_load   = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (w_expire) begin
                        w_next_state = GAP;
                        w_tmr_load   = 1'b1;
                        w_tmr_limit  = T_W'(OFF_TICKS - 1);
                    end
                end
                GAP: begin
                    if (w_expire) begin
                        if (w_last) begin
                            w_next_state = DONE;
                        end else begin
                            w_next_state = SHOW;
                            w_tmr_load   = 1'b1;
                        end
                    end
                end
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        led  = '0;
        busy = (r_state != IDLE);
        done = (r_state == DONE);
        if (r_state == SHOW) begin
            led = LED_W'(sym_to_onehot(3'(w_sym)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap <= '0;
            r_rev  <= 1'b0;
            r_len  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_snap <= pattern;
            r_rev  <= reverse;
            r_len  <= w_eff_len;
            if (reverse || (w_eff_len == '0)) begin
                r_idx <= '0;
            end else begin
                r_idx <= IDX_W'(w_eff_len - LEN_W'(1));
            end
        end else if ((r_state == GAP) && w_expire && !w_last && !abort) begin
            r_idx <= r_rev ? (r_idx + 1'b1) : (r_idx - 1'b1);
        end
    end

endmodule

// File: doc/pattern_player.md
# pattern_player

Timed playback engine for the memory game's LED side. It snapshots the packed 3-bit symbol pattern built by the pattern shift register and presents it to the player one symbol at a time on the one-hot LED bus. Each symbol is followed by a dark gap, in forward order or reversed order. It is the game-to-player transmitter paired with the player-to-game input handler. The mode FSMs start it after pattern generation and open input capture on `done`.

## Interface

Parameters:
- `SYM_W`, 3: bits per symbol; 8 LEDs.
- `MAX_LEN`, 25: max symbols held (`PAT_W = SYM_W*MAX_LEN = 75`).
- `ON_TICKS`, 2: tick strobes each symbol is lit; must be ≥1.
- `OFF_TICKS`, 1: tick strobes of dark gap after each symbol; must be ≥1.
- `CNT_W`, 16: width of length input, matching the game counter.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: pulse; begin playback (sampled only in IDLE).
- `abort`, in, 1: level; return to IDLE next cycle (play_again path).
- `reverse`, in, 1: playback order, latched with `start`.
- `len`, in, CNT_W: number of valid symbols, latched with `start`.
- `pattern`, in, PAT_W: packed symbols, newest at [2:0], latched with `start`.
- `tick_en`, in, 1: one-cycle strobe from external divider; tie 1 for cycle timing.
- `led`, out, 8: one-hot current symbol, 0 when dark.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse when playback completes.

## Operation

- States: IDLE, SHOW, GAP, DONE.
- IDLE with `start=1` latches `pattern`, `reverse`, and `eff_len = min(len, MAX_LEN)`.
  - `eff_len==0`: go to DONE.
  - Otherwise go to SHOW, with tick counter 0.
- Symbol k occupies bits [3k+2:3k]; k=0 is the newest.
  - Forward order plays oldest first: k = eff_len-1 down to 0.
  - Reverse order plays k = 0 up to eff_len-1.
- SHOW: `led = 1 << sym`. On each `tick_en`:
  - If the tick counter equals ON_TICKS-1, go to GAP and clear the counter.
  - Otherwise increment the counter.
- GAP: `led = 0`. On the `tick_en` where the counter equals OFF_TICKS-1:
  - If the current symbol was the last one, go to DONE.
  - Otherwise advance the index and go to SHOW.
- DONE: `done=1` for one cycle, `led=0`, then IDLE.
- `abort` has priority over everything except reset: next state is IDLE, `led=0`, no `done` pulse.
- `start` is ignored outside IDLE. `start` and `abort` together in IDLE means stay IDLE.
- Changes on `pattern`/`len` after the latch have no effect until the next `start`.

## Timing

- Reset (synchronous, `rst_n=0` at an edge):
  - State goes to IDLE.
  - `led=0`, `busy=0`, `done=0`.
  - Index, tick counter and snapshot registers are cleared.
  - Reset mid-playback behaves the same.
- Latency: `start` sampled at edge 0 gives first symbol on `led` and `busy=1` from cycle 1.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- With `tick_en` tied 1, each symbol takes exactly ON_TICKS+OFF_TICKS cycles.
  - Total playback: `eff_len*(ON_TICKS+OFF_TICKS)` cycles, plus one DONE cycle.
  - `busy` falls the cycle after `done`.
- `tick_en` low freezes the tick counter; state and `led` hold.
- Index width is ceil(log2(MAX_LEN)).
- `len > MAX_LEN` clamps to MAX_LEN with no error flag.

## Structure

- Shared package `memory_game_pkg` holds:
  - `SYM_W`, `MAX_LEN`, `PAT_W` constants.
  - `player_state_t` enum {IDLE, SHOW, GAP, DONE}.
  - Function `sym_to_onehot(logic [2:0]) -> logic [7:0]`, reused by the input side.
- Sub-module `tick_timer` is natural. It is a load/count/expire counter driven by `tick_en`, reloaded to ON_TICKS or OFF_TICKS by the FSM.
- Symbol extraction is a variable part-select `snap[3*idx +: 3]` in the top module.

## Test plan

Common setup: ON_TICKS=2, OFF_TICKS=1, `tick_en=1`. Symbols 3,5,1 were shifted in (oldest first), so `pattern[8:0] = 9'b011_101_001`, `len=3`.

- **Forward playback:** `start` at c0 gives:
  - `led` = 0x08 (c1–2), 0 (c3), 0x20 (c4–5), 0 (c6), 0x02 (c7–8), 0 (c9).
  - `done=1` at c10 only; `busy=0` at c11.
- **Reverse playback:** same pattern with `reverse=1` gives `led` order 0x02, 0x20, 0x08 at the same cycle positions.
- **Empty and clamp:**
  - `len=0`: `done` at c1, `led` stays 0.
  - `len=40`: exactly 25 symbols shown, `done` at c76.
- **Abort and stray start:**
  - `abort` at c5: `led=0`, `busy=0` at c6, no `done` pulse.
  - `start` re-pulsed at c4 of a normal run: ignored, timing unchanged.
- **Reset and tick stall:**
  - `rst_n=0` at c4: all outputs 0 from c5.
  - `tick_en` held low c2–c6 after start: `led` stays 0x08 through c7.
